uart_rx_core: RTL and testbench

Self-contained 8N1 UART receiver for the 50 MHz board clock. It contains its own baud counter, selected at run time by a 2-bit rate code. The block synchronises the serial input, validates the start bit and samples each bit at mid-period. It delivers one byte per frame as a single-cycle strobe and flags framing errors. It sits between the board RX pin and the command/readout logic, as the receive side of the UART link.

---
 rtl/uart_rx_core_pkg.sv | 33 +++
 rtl/uart_sync_2ff.sv | 24 ++
 rtl/uart_rx_core.sv | 129 ++++++++++++
 tb/tb_uart_rx_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_core_pkg.sv
// Shared UART definitions: rate codes, receiver FSM encoding and
// clock-derived baud divisors used by both the receive and transmit sides.
package uart_rx_core_pkg;

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_38400  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Clocks per bit, rounded down; callers pass a constant clk_hz so this folds.
  function automatic int unsigned baud_div(input logic [1:0] rate, input int unsigned clk_hz);
    int unsigned hz;
    case (rate)
      BAUD_9600:  hz = 9600;
      BAUD_19200: hz = 19200;
      BAUD_38400: hz = 38400;
      default:    hz = 115200;
    endcase
    return clk_hz / hz;
  endfunction

  function automatic int unsigned baud_half(input logic [1:0] rate, input int unsigned clk_hz);
    return baud_div(rate, clk_hz) / 2;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// reset to RST_VAL so an idle-high line stays quiet through reset.
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with run-time rate select: start-bit validation at
// half period, mid-bit sampling, one-cycle byte and framing-error strobes.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 13
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic [1:0] baud_rate,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  logic             rxd_s;
  logic             rxd_prev;
  uart_state_t      state;
  uart_state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_lat;
  logic [CNT_W-1:0] half_lat;
  logic [CNT_W-1:0] div_tab  [4];
  logic [CNT_W-1:0] half_tab [4];
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             start_det;
  logic             half_hit;
  logic             full_hit;
  logic             ld_start;
  logic             shift_en;
  logic             done_ok;
  logic             done_err;
  logic             cnt_clr;

  uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rxd),
    .q       (rxd_s)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_div
    assign div_tab[gi]  = CNT_W'(baud_div(2'(gi), CLK_HZ));
    assign half_tab[gi] = CNT_W'(baud_half(2'(gi), CLK_HZ));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rxd_prev <= 1'b1;
    else          rxd_prev <= rxd_s;
  end

  // Equality compares only: a freshly latched smaller divisor can never be overrun.
  assign start_det = rxd_prev & ~rxd_s;
  assign half_hit  = (cnt == half_lat - CNT_W'(1));
  assign full_hit  = (cnt == div_lat - CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_det) state_next = ST_START;
      ST_START: if (half_hit) state_next = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (full_hit && bit_idx == 3'd7) state_next = ST_STOP;
      ST_STOP:  if (full_hit) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_start = 1'b0;
    shift_en = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    cnt_clr  = 1'b1;
    rx_busy  = 1'b1;
    case (state)
      ST_IDLE: begin
        rx_busy  = 1'b0;
        ld_start = start_det;
      end
      ST_START: cnt_clr = half_hit;
      ST_DATA: begin
        shift_en = full_hit;
        cnt_clr  = full_hit;
      end
      ST_STOP: begin
        cnt_clr  = full_hit;
        done_ok  = full_hit & rxd_s;
        done_err = full_hit & ~rxd_s;
      end
      default: rx_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      div_lat      <= '0;
      half_lat     <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= done_ok;
      rx_frame_err <= done_err;
      cnt          <= cnt_clr ? '0 : cnt + CNT_W'(1);
      // Rate is frozen per frame so a mid-frame baud_rate change waits for the next start.
      if (ld_start) begin
        div_lat  <= div_tab[baud_rate];
        half_lat <= half_tab[baud_rate];
      end
      if (state == ST_START) bit_idx <= '0;
      else if (shift_en)     bit_idx <= bit_idx + 3'd1;
      if (shift_en) shreg <= {rxd_s, shreg[7:1]};
      if (done_ok)  rx_data <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomised and directed frames driven on the pin; a frame-level model
// predicts each strobe's kind, byte and cycle from the bit-timing rules.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int unsigned TB_CLK_HZ = 10_000_000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] baud_rate = 2'b00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  always #5 clk = ~clk;

  uart_rx_core #(.CLK_HZ(TB_CLK_HZ), .CNT_W(13)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rxd          (rxd),
    .baud_rate    (baud_rate),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  // kind: 1 = byte strobe, 2 = framing error, 3 = both at once
  typedef struct {
    int kind;
    int data;
    int cyc;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         obs_rd = 0;
  int         cyc = 0;
  int         busy_total = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_busy) busy_total <= busy_total + 1;
      if (rx_valid || rx_frame_err)
        obs_q.push_back('{(rx_valid ? 1 : 0) + (rx_frame_err ? 2 : 0), int'(rx_data), cyc});
    end
  end

  function automatic int div_of(input int code);
    case (code)
      0:       return TB_CLK_HZ / 9600;
      1:       return TB_CLK_HZ / 19200;
      2:       return TB_CLK_HZ / 38400;
      default: return TB_CLK_HZ / 115200;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame at the current baud_rate; a low stop bit may be stretched by extra_low.
  task automatic send_frame(input string tag, input logic [7:0] b, input logic stop,
                            input int extra_low, input int chg_bit, input logic [1:0] chg_rate);
    int dv;
    int hf;
    int fall;
    dv   = div_of(int'(baud_rate));
    hf   = dv / 2;
    fall = cyc;
    rxd  = 1'b0;
    tick(dv);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      if (k == chg_bit) baud_rate = chg_rate;
      tick(dv);
    end
    rxd = stop;
    tick(stop ? dv : dv + extra_low);
    rxd = 1'b1;
    if (stop) begin
      exp_q.push_back('{1, int'(b), fall + 3 + hf + 9 * dv});
      last_good = b;
    end else begin
      exp_q.push_back('{2, int'(last_good), fall + 3 + hf + 9 * dv});
    end
    $display("frame %s: byte=%02h div=%0d stop=%0d fall_cycle=%0d", tag, b, dv, stop, fall);
  endtask

  task automatic compare_events(input string tag);
    check_eq({tag, " event count"}, obs_q.size() - obs_rd, exp_q.size());
    foreach (exp_q[i]) begin
      if (obs_rd + i < obs_q.size()) begin
        check_eq({tag, " kind"}, obs_q[obs_rd + i].kind, exp_q[i].kind);
        check_eq({tag, " data"}, obs_q[obs_rd + i].data, exp_q[i].data);
        check_eq({tag, " cycle"}, obs_q[obs_rd + i].cyc, exp_q[i].cyc);
      end
    end
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int dv;
    int hf;
    logic [7:0] rb;
    logic       rs;

    tick(3);
    check_eq("reset rx_data", rx_data, 8'h00);
    check_eq("reset rx_valid", rx_valid, 1'b0);
    check_eq("reset rx_frame_err", rx_frame_err, 1'b0);
    check_eq("reset rx_busy", rx_busy, 1'b0);
    reset_n = 1'b1;
    tick(5);

    // 115200: single byte, latency and busy length
    baud_rate = 2'b11;
    dv = div_of(3);
    b0 = busy_total;
    send_frame("s1", 8'hA5, 1'b1, 0, -1, 2'b00);
    tick(4);
    check_eq("s1 busy cycles", busy_total - b0, dv / 2 + 9 * dv);
    check_eq("s1 rx_data", rx_data, 8'hA5);
    compare_events("s1");
    tick(20);

    // 9600: back-to-back 0x00 then 0xFF
    baud_rate = 2'b00;
    dv = div_of(0);
    b0 = busy_total;
    send_frame("s2a", 8'h00, 1'b1, 0, -1, 2'b00);
    send_frame("s2b", 8'hFF, 1'b1, 0, -1, 2'b00);
    tick(4);
    check_eq("s2 busy cycles", busy_total - b0, 2 * (dv / 2 + 9 * dv));
    compare_events("s2");
    tick(20);

    // 38400: short low pulse is rejected at half period
    baud_rate = 2'b10;
    hf = div_of(2) / 2;
    b0 = busy_total;
    rxd = 1'b0;
    tick(hf / 2);
    rxd = 1'b1;
    $display("glitch s3: low for %0d cycles, half=%0d", hf / 2, hf);
    tick(hf + 20);
    check_eq("s3 busy cycles", busy_total - b0, hf);
    check_eq("s3 rx_busy after abort", rx_busy, 1'b0);
    compare_events("s3");

    // 19200: low stop bit, line held low afterwards must not retrigger
    baud_rate = 2'b01;
    dv = div_of(1);
    b0 = busy_total;
    send_frame("s4", 8'h3C, 1'b0, 3 * dv, -1, 2'b00);
    tick(dv);
    check_eq("s4 busy cycles", busy_total - b0, dv / 2 + 9 * dv);
    check_eq("s4 rx_data held", rx_data, last_good);
    compare_events("s4");

    // 115200 frame with baud change to 9600 during bit 3, then a 9600 frame
    baud_rate = 2'b11;
    send_frame("s5a", 8'h81, 1'b1, 0, 3, 2'b00);
    tick(30);
    send_frame("s5b", 8'h42, 1'b1, 0, -1, 2'b00);
    tick(4);
    compare_events("s5");

    // Reset mid-DATA discards the frame, then 0x5A must still be received
    baud_rate = 2'b11;
    dv = div_of(3);
    rxd = 1'b0;
    tick(dv / 2 + 2 * dv + 5);
    check_eq("s6 busy mid data", rx_busy, 1'b1);
    reset_n = 1'b0;
    rxd = 1'b1;
    #1;
    check_eq("s6 reset rx_data", rx_data, 8'h00);
    check_eq("s6 reset rx_valid", rx_valid, 1'b0);
    check_eq("s6 reset rx_frame_err", rx_frame_err, 1'b0);
    check_eq("s6 reset rx_busy", rx_busy, 1'b0);
    tick(5);
    reset_n = 1'b1;
    last_good = 8'h00;
    tick(20);
    check_eq("s6 idle after reset", rx_busy, 1'b0);
    check_eq("s6 rx_data after reset", rx_data, 8'h00);
    compare_events("s6 reset");
    send_frame("s6", 8'h5A, 1'b1, 0, -1, 2'b00);
    tick(4);
    compare_events("s6");

    // Random frames at the faster rates, occasional bad stop bit
    for (int i = 0; i < 8; i++) begin
      baud_rate = 2'($urandom_range(2, 3));
      dv = div_of(int'(baud_rate));
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      send_frame("rnd", rb, rs, $urandom_range(0, dv), -1, 2'b00);
      tick($urandom_range(4, 200));
      compare_events("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
